// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART TX constants: frame states, FIFO flags, parity and stop options
package uart_tx_pkg;

  localparam int         DATA_BITS = 8;
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

  typedef enum logic [4:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } state_e;

  localparam logic EMPTY    = 1'b1;
  localparam logic NONEMPTY = 1'b0;
  localparam logic EVEN     = 1'b0;
  localparam logic ODD      = 1'b1;
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Parity bit the shift register sends for a byte under the selected method
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic method);
    logic p;
    case (method)
      EVEN:    p = ^data;
      ODD:     p = ~^data;
      default: p = ^data;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// rtl/uart_tx_fsm_if.sv - control/status bundle between baud/FIFO side and the TX frame sequencer
interface uart_tx_fsm_if;

  logic       p_BaudSig_i;
  logic       p_FiFoEmpty_i;
  logic       p_TxEnable_i;
  logic       p_ParityEnable_i;
  logic       StopBits_i;
  logic [4:0] State_o;
  logic [3:0] BitCounter_o;
  logic       p_TxBusy_o;
  logic       p_FrameDone_o;

  modport master (
    output p_BaudSig_i, p_FiFoEmpty_i, p_TxEnable_i, p_ParityEnable_i, StopBits_i,
    input  State_o, BitCounter_o, p_TxBusy_o, p_FrameDone_o
  );

  modport slave (
    input  p_BaudSig_i, p_FiFoEmpty_i, p_TxEnable_i, p_ParityEnable_i, StopBits_i,
    output State_o, BitCounter_o, p_TxBusy_o, p_FrameDone_o
  );

endinterface

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame sequencer: one-hot frame state and bit index, stepped by baud pulses
module uart_tx_fsm
  import uart_tx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  uart_tx_fsm_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       stop2_q, stop2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       state_ok;
  logic       illegal;

  always_comb begin
    case (state_q)
      INTERVAL, STARTBIT, DATABITS, PARITYBIT, STOPBIT: state_ok = 1'b1;
      default:                                          state_ok = 1'b0;
    endcase
  end

  // Corrupted state or counter recovers to idle without waiting for a baud
  assign illegal = !state_ok || (state_q == DATABITS && cnt_q > LAST_BIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    if (illegal) begin
      state_d = INTERVAL;
      cnt_d   = '0;
    end else if (bus.p_BaudSig_i) begin
      case (state_q)
        INTERVAL: begin
          // Same condition the shift register uses to pop the FIFO
          if (bus.p_FiFoEmpty_i == NONEMPTY && bus.p_TxEnable_i) begin
            state_d = STARTBIT;
            cnt_d   = '0;
            par_d   = bus.p_ParityEnable_i;
            stop2_d = bus.StopBits_i;
          end
        end
        STARTBIT: begin
          state_d = DATABITS;
          cnt_d   = '0;
        end
        DATABITS: begin
          if (cnt_q < LAST_BIT) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = par_q ? PARITYBIT : STOPBIT;
          end
        end
        PARITYBIT: begin
          state_d = STOPBIT;
          cnt_d   = '0;
        end
        STOPBIT: begin
          if (stop2_q == STOP_TWO && cnt_q == 4'd0) begin
            cnt_d = 4'd1;
          end else begin
            state_d = INTERVAL;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = INTERVAL;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != INTERVAL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INTERVAL;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      stop2_q <= STOP_ONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.State_o       = state_q;
  assign bus.BitCounter_o  = cnt_q;
  assign bus.p_TxBusy_o    = busy_q;
  assign bus.p_FrameDone_o = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - scoreboard bench for uart_tx_fsm: expected transitions queued, monitor compares
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  typedef struct {
    logic [4:0] st;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_count = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  bit   have_done = 0;
  exp_t exp_q[$];
  int   busy_lens[$];
  int   gaps[$];
  logic [4:0] prev_st = 5'b00001;
  logic [3:0] prev_cnt = 4'd0;

  uart_tx_fsm_if bus ();

  uart_tx_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] st, input logic [3:0] cnt, input logic busy, input logic done);
    exp_t e;
    e.st = st; e.cnt = cnt; e.busy = busy; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input bit par, input bit stop2);
    push(5'b00010, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) push(5'b00100, 4'(i), 1'b1, 1'b0);
    if (par) push(5'b01000, 4'd0, 1'b1, 1'b0);
    push(5'b10000, 4'd0, 1'b1, 1'b0);
    if (stop2) push(5'b10000, 4'd1, 1'b1, 1'b0);
    push(5'b00001, 4'd0, 1'b0, 1'b1);
  endtask

  // One baud period of 16 clks; the pulse is sampled on the second edge
  task automatic baud_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 bus.p_BaudSig_i = 1'b1;
      @(posedge clk); #1 bus.p_BaudSig_i = 1'b0;
      repeat (14) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_busy(input string name, input int exp);
    if (busy_lens.size() == 0) check({name, "_missing"}, 0, 1);
    else check(name, busy_lens.pop_front(), exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.State_o !== prev_st || bus.BitCounter_o !== prev_cnt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_state_change", int'(bus.State_o), int'(prev_st));
      end else begin
        e = exp_q.pop_front();
        check("state", int'(bus.State_o), int'(e.st));
        check("bitcnt", int'(bus.BitCounter_o), int'(e.cnt));
        check("busy", int'(bus.p_TxBusy_o), int'(e.busy));
        check("framedone", int'(bus.p_FrameDone_o), int'(e.done));
      end
      if (bus.State_o == 5'b00010) begin
        start_cyc = cyc;
        if (have_done) gaps.push_back(cyc - done_cyc);
        have_done = 0;
      end
    end else if (bus.p_FrameDone_o) begin
      check("spurious_framedone", 1, 0);
    end
    if (bus.p_FrameDone_o) begin
      done_count++;
      done_cyc = cyc;
      have_done = 1;
      busy_lens.push_back(cyc - start_cyc);
    end
    prev_st  = bus.State_o;
    prev_cnt = bus.BitCounter_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.p_BaudSig_i      = 1'b0;
    bus.p_FiFoEmpty_i    = EMPTY;
    bus.p_TxEnable_i     = 1'b1;
    bus.p_ParityEnable_i = 1'b0;
    bus.StopBits_i       = STOP_ONE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(bus.State_o), 1);
    check("rst_cnt", int'(bus.BitCounter_o), 0);
    check("rst_busy", int'(bus.p_TxBusy_o), 0);
    check("rst_done", int'(bus.p_FrameDone_o), 0);
    rst = 1'b1;

    // FIFO empty: no start despite bauds
    baud_ticks(2);
    check("idle_empty_state", int'(bus.State_o), 1);

    // Frame 1: no parity, one stop bit
    d0 = done_count;
    bus.p_FiFoEmpty_i = NONEMPTY;
    push_frame(0, 0);
    baud_ticks(11);
    bus.p_FiFoEmpty_i = EMPTY;
    check("f1_done_pulses", done_count - d0, 1);
    check_busy("f1_busy_clks", 160);

    // Frame 2: parity, two stop bits
    d0 = done_count;
    bus.p_ParityEnable_i = 1'b1;
    bus.StopBits_i = STOP_TWO;
    bus.p_FiFoEmpty_i = NONEMPTY;
    push_frame(1, 1);
    baud_ticks(13);
    bus.p_FiFoEmpty_i = EMPTY;
    check("f2_done_pulses", done_count - d0, 1);
    check_busy("f2_busy_clks", 192);

    // Options toggled mid-frame only affect the following frame
    d0 = done_count;
    bus.p_ParityEnable_i = 1'b0;
    bus.StopBits_i = STOP_ONE;
    bus.p_FiFoEmpty_i = NONEMPTY;
    push_frame(0, 0);
    push_frame(1, 1);
    baud_ticks(4);
    bus.p_ParityEnable_i = 1'b1;
    bus.StopBits_i = STOP_TWO;
    baud_ticks(20);
    bus.p_FiFoEmpty_i = EMPTY;
    check("opt_done_pulses", done_count - d0, 2);
    check_busy("opt_f1_busy_clks", 160);
    check_busy("opt_f2_busy_clks", 192);
    check("opt_gap_clks", (gaps.size() > 0) ? gaps[$] : -1, 16);

    // Back-to-back frames; enable dropped in frame 2 stops frame 3
    d0 = done_count;
    bus.p_ParityEnable_i = 1'b0;
    bus.StopBits_i = STOP_ONE;
    bus.p_FiFoEmpty_i = NONEMPTY;
    push_frame(0, 0);
    push_frame(0, 0);
    baud_ticks(14);
    bus.p_TxEnable_i = 1'b0;
    baud_ticks(11);
    check("en_done_pulses", done_count - d0, 2);
    check("en_gap_clks", (gaps.size() > 0) ? gaps[$] : -1, 16);
    check("en_hold_idle", int'(bus.State_o), 1);
    check_busy("en_f1_busy_clks", 160);
    check_busy("en_f2_busy_clks", 160);
    bus.p_TxEnable_i = 1'b1;
    bus.p_FiFoEmpty_i = EMPTY;

    // Reset in DATABITS at index 4
    d0 = done_count;
    bus.p_FiFoEmpty_i = NONEMPTY;
    push(5'b00010, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(5'b00100, 4'(i), 1'b1, 1'b0);
    push(5'b00001, 4'd0, 1'b0, 1'b0);
    baud_ticks(6);
    check("pre_rst_cnt", int'(bus.BitCounter_o), 4);
    rst = 1'b0;
    #1;
    check("async_rst_state", int'(bus.State_o), 1);
    check("async_rst_cnt", int'(bus.BitCounter_o), 0);
    check("async_rst_busy", int'(bus.p_TxBusy_o), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push_frame(0, 0);
    baud_ticks(11);
    bus.p_FiFoEmpty_i = EMPTY;
    check("post_rst_done_pulses", done_count - d0, 1);
    check_busy("post_rst_busy_clks", 160);

    // Illegal one-hot value recovers without baud and without FrameDone
    d0 = done_count;
    push(5'b00110, 4'd0, 1'b0, 1'b0);
    push(5'b00001, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 force dut.state_q = state_e'(5'b00110);
    #1 check("forced_state", int'(bus.State_o), 6);
    @(negedge clk);
    #1 release dut.state_q;
    @(posedge clk);
    #1;
    check("illegal_recover_state", int'(bus.State_o), 1);
    check("illegal_recover_cnt", int'(bus.BitCounter_o), 0);
    check("illegal_no_done", int'(bus.p_FrameDone_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check("illegal_done_pulses", done_count - d0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
Transmit-side frame sequencer of the UART without a bus interface. It sits between the baud-rate generator / TX FIFO and the TX shift register. It drives the one-hot frame state (State_o) and the bit index (BitCounter_o) that the shift register uses to serialise the byte. Frame timing advances only on baud pulses. Frame options (parity enable, stop-bit count) are sampled once per frame.

Parameters:
DATA_BITS, 8, data bits per frame; fixed at 8 to match the shift register's byte width; BitCounter_o range is 0..DATA_BITS-1.

Ports:
clk  input  1  system clock, >= 40 MHz.
rst  input  1  asynchronous reset, active low; release is synchronous to clk.
p_BaudSig_i  input  1  one-clk-wide pulse, once per bit period, from the baud-rate module.
p_FiFoEmpty_i  input  1  TX FIFO empty flag: 1 = empty, 0 = non-empty.
p_TxEnable_i  input  1  1 = new frames may start; 0 = hold idle after the current frame completes.
p_ParityEnable_i  input  1  1 = insert a PARITYBIT state.
StopBits_i  input  1  0 = one stop bit, 1 = two stop bits.
State_o  output  5  one-hot state: INTERVAL 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000.
BitCounter_o  output  4  data-bit index in DATABITS, stop-bit index in STOPBIT, 0 otherwise.
p_TxBusy_o  output  1  1 whenever State_o != INTERVAL.
p_FrameDone_o  output  1  one-clk pulse on the clk edge that leaves STOPBIT.

Behaviour:
- Reset values: State_o = INTERVAL, BitCounter_o = 0, p_TxBusy_o = 0, p_FrameDone_o = 0, latched options = 0.
- All outputs are registered. The state changes on the clk edge at which p_BaudSig_i is sampled 1, and never at any other time.
- INTERVAL -> STARTBIT:
  - Condition: p_BaudSig_i = 1 AND p_FiFoEmpty_i = 0 AND p_TxEnable_i = 1.
  - This is exactly the condition the shift register uses to assert its FIFO read. Its data is therefore loaded within 2 clks, before the first DATABITS baud.
  - On the same edge, latch p_ParityEnable_i and StopBits_i into internal registers used for the whole frame.
- STARTBIT -> DATABITS on baud; BitCounter_o = 0.
- DATABITS, on each baud:
  - If BitCounter_o < DATA_BITS-1: increment BitCounter_o.
  - Else: clear BitCounter_o to 0 and go to PARITYBIT if latched parity enable = 1, otherwise STOPBIT.
- PARITYBIT -> STOPBIT on baud; BitCounter_o = 0.
- STOPBIT, on baud:
  - If latched StopBits = 1 and BitCounter_o = 0: BitCounter_o = 1 and stay in STOPBIT.
  - Otherwise: go to INTERVAL, BitCounter_o = 0, pulse p_FrameDone_o for 1 clk.
- Frame length in baud periods: 1 + 8 + parity (0/1) + stop (1/2).
- Back-to-back frames: INTERVAL always lasts at least one baud period, so consecutive frames carry one extra idle (mark) bit. This is intended.
- Option changes mid-frame: p_ParityEnable_i and StopBits_i changes have no effect until the next INTERVAL -> STARTBIT edge.
- p_TxEnable_i deasserted mid-frame: the frame completes normally, and the FSM then stays in INTERVAL.
- FIFO empty while in INTERVAL: remain in INTERVAL indefinitely with no output change.
- p_BaudSig_i is ignored on any clk where it is 0. Back-to-back 1s are each treated as separate bit periods (no filtering).
- Illegal State_o value (not one-hot), or BitCounter_o > DATA_BITS-1 in DATABITS: force State_o = INTERVAL and BitCounter_o = 0 on the next clk, independent of baud. p_FrameDone_o is not pulsed.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The partial frame is abandoned; the line returns to mark via the shift register.
- Latency note: the shift register registers the serial bit from State_o, so the tx pin lags each state transition by 1 clk.

Decomposition:
- Shared package uart_tx_pkg:
  - state encodings INTERVAL/STARTBIT/DATABITS/PARITYBIT/STOPBIT (5-bit one-hot);
  - FIFO flags EMPTY = 1, NONEMPTY = 0;
  - parity method constants EVEN = 0, ODD = 1;
  - STOP_ONE = 0, STOP_TWO = 1;
  - DATA_BITS.
- The shift register imports the same state constants.
- No sub-module: the FSM and counter are a single block.

Test Plan:
- FIFO non-empty, parity off, 1 stop, baud every 16 clks -> STARTBIT, DATABITS with BitCounter 0..7, STOPBIT, INTERVAL; 10 baud periods busy; p_FrameDone_o pulses exactly once.
- Parity on, 2 stop bits -> sequence START, D0..D7, PARITYBIT, STOPBIT(cnt 0), STOPBIT(cnt 1), INTERVAL; 12 baud periods busy.
- Toggle p_ParityEnable_i and StopBits_i during DATABITS -> current frame uses the options latched at start; the next frame uses the new values.
- Keep FIFO non-empty for 3 frames -> exactly 1 INTERVAL baud period between frames; drop p_TxEnable_i in frame 2 -> frame 2 finishes, frame 3 never starts.
- Assert rst in DATABITS at BitCounter = 4 -> State_o = 00001 and BitCounter_o = 0 immediately; after release, the next frame starts cleanly on the first eligible baud.
- Force State_o to 00110 via the bench -> INTERVAL on the next clk with no baud pulse; p_FrameDone_o stays 0.
